id_ex_pipe_reg: RTL and testbench

ID/EX pipeline register, directly downstream of the ID-stage flush gating of the control-unit outputs. It captures the gated control bits, register-file read data, sign-extended immediate and register specifiers at each clock edge, and presents them to the EX stage, the forwarding unit and the hazard unit. It supports stall (hold), flush (bubble insertion) and a valid bit per entry.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_field_reg.sv | 25 ++
 rtl/id_ex_pipe_reg.sv | 133 +++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: the EX-stage control bundle, its NOP value,
// default datapath widths and the ALUOp encodings.
package pipe_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;
        logic    alu_src;
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        alu_op_e alu_op;
    } ctrl_ex_t;

    localparam ctrl_ex_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: synchronous clear beats hold beats load,
// with an asynchronous active-low reset to zero.
module pipe_field_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         hold,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Field storage: reset, then clear, then hold, otherwise capture d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register. Captures gated control, register read data,
// immediate and register specifiers; supports stall (hold), flush (bubble)
// and a per-entry valid bit.
// Optional macro ID_EX_BUBBLE_CNT_EN adds a saturating 32-bit bubble_cnt
// output counting every edge that writes an invalid entry.
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W     = pipe_pkg::DATA_W,
    parameter int unsigned REG_ADDR_W = pipe_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_reg_dst,
    input  logic                  id_alu_src,
    input  logic                  id_mem_to_reg,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_branch,
    input  logic [1:0]            id_alu_op,
    input  logic [DATA_W-1:0]     id_pc_plus4,
    input  logic [DATA_W-1:0]     id_rd1,
    input  logic [DATA_W-1:0]     id_rd2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    output logic                  ex_valid,
    output logic                  ex_reg_dst,
    output logic                  ex_alu_src,
    output logic                  ex_mem_to_reg,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_branch,
    output logic [1:0]            ex_alu_op,
    output logic [DATA_W-1:0]     ex_pc_plus4,
    output logic [DATA_W-1:0]     ex_rd1,
    output logic [DATA_W-1:0]     ex_rd2,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [31:0]           bubble_cnt
`endif
);

    import pipe_pkg::*;

    localparam int unsigned CTRL_W = $bits(ctrl_ex_t) + 1;
    localparam int unsigned DBUS_W = 4 * DATA_W + 3 * REG_ADDR_W;

    ctrl_ex_t          ctrl_in;
    ctrl_ex_t          ctrl_gated;
    ctrl_ex_t          ctrl_q;
    logic [CTRL_W-1:0] ctrl_bus_d;
    logic [CTRL_W-1:0] ctrl_bus_q;
    logic [DBUS_W-1:0] data_bus_d;
    logic [DBUS_W-1:0] data_bus_q;

    // Pack control inputs and suppress them when the ID entry is not valid.
    always_comb begin
        ctrl_in            = CTRL_NOP;
        ctrl_in.reg_dst    = id_reg_dst;
        ctrl_in.alu_src    = id_alu_src;
        ctrl_in.mem_to_reg = id_mem_to_reg;
        ctrl_in.reg_write  = id_reg_write;
        ctrl_in.mem_read   = id_mem_read;
        ctrl_in.mem_write  = id_mem_write;
        ctrl_in.branch     = id_branch;
        ctrl_in.alu_op     = alu_op_e'(id_alu_op);
        ctrl_gated         = id_valid ? ctrl_in : CTRL_NOP;
    end

    assign ctrl_bus_d = {id_valid, ctrl_gated};
    assign data_bus_d = {id_pc_plus4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd};

    // Flush clears the stage even when stall is also asserted.
    pipe_field_reg #(.W(CTRL_W)) u_ctrl_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .hold  (stall),
        .d     (ctrl_bus_d),
        .q     (ctrl_bus_q)
    );

    pipe_field_reg #(.W(DBUS_W)) u_data_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .hold  (stall),
        .d     (data_bus_d),
        .q     (data_bus_q)
    );

    assign ctrl_q   = ctrl_bus_q[CTRL_W-2:0];
    assign ex_valid = ctrl_bus_q[CTRL_W-1];

    // Unpack the registered control bundle onto the EX-facing outputs.
    always_comb begin
        ex_reg_dst    = ctrl_q.reg_dst;
        ex_alu_src    = ctrl_q.alu_src;
        ex_mem_to_reg = ctrl_q.mem_to_reg;
        ex_reg_write  = ctrl_q.reg_write;
        ex_mem_read   = ctrl_q.mem_read;
        ex_mem_write  = ctrl_q.mem_write;
        ex_branch     = ctrl_q.branch;
        ex_alu_op     = ctrl_q.alu_op;
    end

    assign {ex_pc_plus4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd} = data_bus_q;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic bubble_inc;

    assign bubble_inc = flush | (~stall & ~id_valid);

    // Count invalid-entry writes, saturating at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (bubble_inc && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg. Inputs change on the
// falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, stall, flush;
    logic        id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write;
    logic        id_mem_read, id_mem_write, id_branch;
    logic [1:0]  id_alu_op;
    logic [31:0] id_pc_plus4, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write;
    logic        ex_mem_read, ex_mem_write, ex_branch;
    logic [1:0]  ex_alu_op;
    logic [31:0] ex_pc_plus4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .stall         (stall),
        .flush         (flush),
        .id_reg_dst    (id_reg_dst),
        .id_alu_src    (id_alu_src),
        .id_mem_to_reg (id_mem_to_reg),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .id_branch     (id_branch),
        .id_alu_op     (id_alu_op),
        .id_pc_plus4   (id_pc_plus4),
        .id_rd1        (id_rd1),
        .id_rd2        (id_rd2),
        .id_imm        (id_imm),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .ex_valid      (ex_valid),
        .ex_reg_dst    (ex_reg_dst),
        .ex_alu_src    (ex_alu_src),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_branch     (ex_branch),
        .ex_alu_op     (ex_alu_op),
        .ex_pc_plus4   (ex_pc_plus4),
        .ex_rd1        (ex_rd1),
        .ex_rd2        (ex_rd2),
        .ex_imm        (ex_imm),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_rd         (ex_rd)
`ifdef ID_EX_BUBBLE_CNT_EN
        ,
        .bubble_cnt    (bubble_cnt)
`endif
    );

    // Control outputs packed {reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,alu_op}
    function automatic logic [8:0] ex_ctrl();
        return {ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
                ex_mem_read, ex_mem_write, ex_branch, ex_alu_op};
    endfunction

    task automatic drive_ctrl(input logic [8:0] c);
        {id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write,
         id_mem_read, id_mem_write, id_branch, id_alu_op} = c;
    endtask

    task automatic drive_data(input logic [31:0] pc, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] im,
                              input logic [4:0] s, input logic [4:0] t,
                              input logic [4:0] d);
        id_pc_plus4 = pc; id_rd1 = r1; id_rd2 = r2; id_imm = im;
        id_rs = s; id_rt = t; id_rd = d;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; id_valid = 1'b1;
        drive_ctrl('1);
        drive_data('1, '1, '1, '1, '1, '1, '1);
        edge_sample();
        @(negedge clk);
        rst_n = 1'b1;
        edge_sample();
        // outputs now all ones; assert reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ex_valid, ex_ctrl(), ex_pc_plus4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd} !== '0) begin
            errors++;
            $display("FAIL reset_async: valid=%b ctrl=%h rd1=%h rs=%h required all zero",
                     ex_valid, ex_ctrl(), ex_rd1, ex_rs);
        end
        edge_sample();
        checks++;
        if ({ex_valid, ex_rd1} !== '0) begin
            errors++;
            $display("FAIL reset_held: valid=%b rd1=%h required 0", ex_valid, ex_rd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_ctrl('0);
        drive_data('0, 32'hDEADBEEF, '0, '0, '0, '0, '0);
        id_valid = 1'b1;
        edge_sample();
        checks++;
        if (ex_rd1 !== 32'hDEADBEEF || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_load: rd1=%h valid=%b required deadbeef 1", ex_rd1, ex_valid);
        end
    endtask

    task automatic test_load();
        @(negedge clk);
        id_valid = 1'b1;
        drive_ctrl(9'b0_1_1_1_1_0_0_00);
        drive_data(32'h0000_1004, 32'h1111_2222, 32'h3333_4444, 32'h4, 5'd3, 5'd9, 5'd17);
        edge_sample();
        checks++;
        if (ex_ctrl() !== 9'b0_1_1_1_1_0_0_00 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL load_ctrl: ctrl=%b valid=%b required 011110000 1", ex_ctrl(), ex_valid);
        end
        checks++;
        if ({ex_pc_plus4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd} !==
            {32'h0000_1004, 32'h1111_2222, 32'h3333_4444, 32'h4, 5'd3, 5'd9, 5'd17}) begin
            errors++;
            $display("FAIL load_data: pc=%h rd1=%h rd2=%h imm=%h rs=%0d rt=%0d rd=%0d", ex_pc_plus4,
                     ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd);
        end
        // R-type with funct ALUOp, then invalid entry with controls all high
        @(negedge clk);
        drive_ctrl(9'b1_0_0_1_0_0_0_10);
        drive_data(32'h2000, 32'h5, 32'h6, 32'hFFFF_FFF0, 5'd1, 5'd2, 5'd4);
        edge_sample();
        checks++;
        if (ex_ctrl() !== 9'b1_0_0_1_0_0_0_10 || ex_rd !== 5'd4) begin
            errors++;
            $display("FAIL load_rtype: ctrl=%b rd=%0d required 100100010 4", ex_ctrl(), ex_rd);
        end
        @(negedge clk);
        id_valid = 1'b0;
        drive_ctrl('1);
        drive_data(32'hA0, 32'hA1, 32'hA2, 32'hA3, 5'd10, 5'd11, 5'd12);
        edge_sample();
        checks++;
        if (ex_ctrl() !== 9'h0 || ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL invalid_gate: ctrl=%b valid=%b required 0 0", ex_ctrl(), ex_valid);
        end
        checks++;
        if (ex_rd2 !== 32'hA2 || ex_rt !== 5'd11) begin
            errors++;
            $display("FAIL invalid_data: rd2=%h rt=%0d required a2 11", ex_rd2, ex_rt);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        id_valid = 1'b1;
        drive_ctrl(9'b1_0_0_1_0_0_0_10);
        drive_data(32'hAAAA_0004, 32'hA1, 32'hA2, 32'hA3, 5'd1, 5'd2, 5'd3);
        edge_sample();
        @(negedge clk);
        stall = 1'b1;
        drive_ctrl(9'b0_1_0_0_0_1_1_01);
        drive_data(32'hBBBB_0004, 32'hB1, 32'hB2, 32'hB3, 5'd21, 5'd22, 5'd23);
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            checks++;
            if (ex_pc_plus4 !== 32'hAAAA_0004 || ex_ctrl() !== 9'b1_0_0_1_0_0_0_10 ||
                ex_rd !== 5'd3 || ex_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: pc=%h ctrl=%b rd=%0d valid=%b required aaaa0004 100100010 3 1",
                         i, ex_pc_plus4, ex_ctrl(), ex_rd, ex_valid);
            end
        end
        @(negedge clk);
        stall = 1'b0;
        edge_sample();
        checks++;
        if (ex_pc_plus4 !== 32'hBBBB_0004 || ex_ctrl() !== 9'b0_1_0_0_0_1_1_01 || ex_rs !== 5'd21) begin
            errors++;
            $display("FAIL stall_release: pc=%h ctrl=%b rs=%0d required bbbb0004 010001101 21",
                     ex_pc_plus4, ex_ctrl(), ex_rs);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        id_valid = 1'b1;
        flush = 1'b1;
        drive_ctrl(9'b0_1_0_0_0_1_0_00);
        drive_data(32'h3004, 32'h10, 32'hCAFE_F00D, 32'h8, 5'd5, 5'd6, 5'd0);
        edge_sample();
        checks++;
        if (ex_mem_write !== 1'b0 || ex_valid !== 1'b0 || ex_rd2 !== 32'h0 ||
            ex_ctrl() !== 9'h0 || ex_rt !== 5'd0) begin
            errors++;
            $display("FAIL flush_bubble: memw=%b valid=%b rd2=%h ctrl=%b rt=%0d required 0",
                     ex_mem_write, ex_valid, ex_rd2, ex_ctrl(), ex_rt);
        end
        @(negedge clk);
        flush = 1'b0;
        edge_sample();
        checks++;
        if (ex_mem_write !== 1'b1 || ex_valid !== 1'b1 || ex_rd2 !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL flush_next_load: memw=%b valid=%b rd2=%h required 1 1 cafef00d",
                     ex_mem_write, ex_valid, ex_rd2);
        end
    endtask

    task automatic test_flush_stall();
        @(negedge clk);
        id_valid = 1'b1;
        flush = 1'b1;
        stall = 1'b1;
        drive_ctrl(9'b1_0_0_1_0_0_0_10);
        drive_data(32'h4004, 32'h1, 32'h2, 32'h3, 5'd7, 5'd8, 5'd9);
        edge_sample();
        checks++;
        if (ex_reg_write !== 1'b0 || ex_valid !== 1'b0 || ex_rd1 !== 32'h0) begin
            errors++;
            $display("FAIL flush_over_stall: regw=%b valid=%b rd1=%h required 0 0 0",
                     ex_reg_write, ex_valid, ex_rd1);
        end
        @(negedge clk);
        flush = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        id_valid = 1'b1;
        flush = 1'b1;
        drive_ctrl(9'b0_1_1_1_1_0_0_00);
        drive_data(32'h5004, 32'h51, 32'h52, 32'h53, 5'd13, 5'd14, 5'd15);
        for (int i = 0; i < 2; i++) begin
            edge_sample();
            checks++;
            if ({ex_valid, ex_ctrl(), ex_imm, ex_rs} !== '0) begin
                errors++;
                $display("FAIL b2b_flush[%0d]: valid=%b ctrl=%b imm=%h rs=%0d required 0",
                         i, ex_valid, ex_ctrl(), ex_imm, ex_rs);
            end
        end
        @(negedge clk);
        flush = 1'b0;
        edge_sample();
        checks++;
        if (ex_ctrl() !== 9'b0_1_1_1_1_0_0_00 || ex_imm !== 32'h53 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_recover: ctrl=%b imm=%h valid=%b required 011110000 53 1",
                     ex_ctrl(), ex_imm, ex_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        stall = 1'b1;
        drive_data(32'h6004, 32'h61, 32'h62, 32'h63, 5'd1, 5'd1, 5'd1);
        edge_sample();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ex_valid, ex_ctrl(), ex_imm} !== '0) begin
            errors++;
            $display("FAIL reset_mid_stall: valid=%b ctrl=%b imm=%h required 0", ex_valid, ex_ctrl(), ex_imm);
        end
        @(negedge clk);
        rst_n = 1'b1;
        edge_sample();
        checks++;
        if (ex_valid !== 1'b0 || ex_imm !== 32'h0) begin
            errors++;
            $display("FAIL reset_then_stall: valid=%b imm=%h required 0 0", ex_valid, ex_imm);
        end
        @(negedge clk);
        stall = 1'b0;
        edge_sample();
        checks++;
        if (ex_valid !== 1'b1 || ex_imm !== 32'h63) begin
            errors++;
            $display("FAIL reset_then_load: valid=%b imm=%h required 1 63", ex_valid, ex_imm);
        end
    endtask

`ifdef ID_EX_BUBBLE_CNT_EN
    task automatic test_bubble_cnt();
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; id_valid = 1'b1;
        #1;
        checks++;
        if (bubble_cnt !== 32'd0) begin
            errors++;
            $display("FAIL bubble_reset: cnt=%0d required 0", bubble_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        flush = 1'b1;
        edge_sample();
        edge_sample();
        @(negedge clk);
        flush = 1'b0;
        id_valid = 1'b0;
        edge_sample();
        @(negedge clk);
        id_valid = 1'b1;
        stall = 1'b1;
        edge_sample();
        edge_sample();
        checks++;
        if (bubble_cnt !== 32'd3) begin
            errors++;
            $display("FAIL bubble_count: cnt=%0d required 3", bubble_cnt);
        end
        @(negedge clk);
        stall = 1'b0;
        force dut.bubble_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.bubble_cnt;
        flush = 1'b1;
        edge_sample();
        checks++;
        if (bubble_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL bubble_to_max: cnt=%h required ffffffff", bubble_cnt);
        end
        edge_sample();
        checks++;
        if (bubble_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL bubble_saturate: cnt=%h required ffffffff", bubble_cnt);
        end
        @(negedge clk);
        flush = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_flush();
        test_flush_stall();
        test_back_to_back();
        test_reset_mid_stall();
`ifdef ID_EX_BUBBLE_CNT_EN
        test_bubble_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
